// File: rtl/switch_capture_ctrl_pkg.sv
// switch_capture_pkg: shared types and constants for the switch/latch/LED
// sequencing controller.
//   mode_e     : LIVE (LEDs follow switches) / REPLAY (LEDs step through slots)
//   LED_W      : width of the switch bus, the LED bus and each capture slot
//   slot_idx_w : width of a slot index for a given slot count (minimum 1 bit)
package switch_capture_pkg;

  typedef enum logic {
    MODE_LIVE   = 1'b0,
    MODE_REPLAY = 1'b1
  } mode_e;

  localparam int unsigned LED_W = 8;

  function automatic int unsigned slot_idx_w(input int unsigned nslots);
    return (nslots <= 2) ? 1 : $clog2(nslots);
  endfunction

endpackage

// File: rtl/switch_capture_ctrl_if.sv
// switch_capture_ctrl_if: board-side bundle of the capture controller.
//   data     : slide switches (asynchronous, into the controller)
//   btn0     : mode button (asynchronous, into the controller)
//   btn1     : capture button (asynchronous, into the controller)
//   led      : registered LED drive
//   q        : most recently captured value
//   latch_en : one-cycle capture strobe
//   mode     : 0 = LIVE, 1 = REPLAY (also the controller's state, for checkers)
//   slot_cnt : number of valid slots, saturating at NSLOTS
//   rd_idx   : slot currently replayed
// Modports: slave = the controller, master = the board / bench side.
//
// Handshake: there is no valid/ready pair. q is qualified by latch_en, which is
// high for exactly one cycle per capture and never on two consecutive cycles;
// every other output is a level that is valid on every cycle.
interface switch_capture_ctrl_if #(
  parameter int unsigned NSLOTS = 4
);
  import switch_capture_pkg::*;

  localparam int unsigned IDX_W = slot_idx_w(NSLOTS);

  logic [LED_W-1:0] data;
  logic             btn0;
  logic             btn1;
  logic [LED_W-1:0] led;
  logic [LED_W-1:0] q;
  logic             latch_en;
  logic             mode;
  logic [IDX_W:0]   slot_cnt;
  logic [IDX_W-1:0] rd_idx;

  modport slave (
    input  data, btn0, btn1,
    output led, q, latch_en, mode, slot_cnt, rd_idx
  );

  modport master (
    output data, btn0, btn1,
    input  led, q, latch_en, mode, slot_cnt, rd_idx
  );

endinterface

// File: rtl/switch_capture_ctrl_btn_debounce.sv
// btn_debounce: two-flop synchroniser, optional stability counter and a
// rising-edge press pulse for one push-button.
//   clk, rst_n : system clock, synchronous active-low reset
//   btn        : raw asynchronous button pin
//   press      : registered one-cycle pulse on each debounced rising edge;
//                releases generate nothing
// Configuration macro SWITCH_CAPTURE_DEBOUNCE_EN:
//   defined   - the debounced level only changes after DEB_CYCLES consecutive
//               synchronised samples that differ from the current level
//   undefined - the edge detect runs directly on the synchronised level and
//               DEB_CYCLES has no effect (simulation / fast-bench build)
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  logic sync1;
  logic sync2;
  logic level;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

`ifdef SWITCH_CAPTURE_DEBOUNCE_EN
  // Counts consecutive samples that disagree with the current level; the
  // DEB_CYCLES-th disagreeing sample flips the level. Any agreeing sample
  // restarts the count, so short glitches never reach the level.
  localparam int unsigned CNT_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);

  logic [CNT_W-1:0] stable_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stable_cnt <= '0;
      level      <= 1'b0;
      press      <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_W'(DEB_CYCLES - 1)) begin
        stable_cnt <= '0;
        level      <= sync2;
        press      <= sync2;
      end else begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end
    end
  end
`else
  logic deb_cycles_unused;
  assign deb_cycles_unused = (DEB_CYCLES != 0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      level <= sync2;
      press <= sync2 & ~level;
    end
  end
`endif

endmodule

// File: rtl/switch_capture_ctrl.sv
// switch_capture_ctrl: sequencing controller between the Basys3 buttons /
// switches and the LEDs. Buttons are synchronised and debounced into press
// pulses; a capture press stores the synchronised switches into a small slot
// bank, and a mode press toggles between showing the live switches and a timed
// replay of the captured slots.
// Ports:
//   clk   : 100 MHz system clock, all logic on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : switch_capture_ctrl_if.slave (data/btn0/btn1 in; led, q, latch_en,
//           mode, slot_cnt, rd_idx out -- all outputs registered)
// Parameters: DEB_CYCLES (debounce length), TICK_CYCLES (cycles per replay
// step, >= 2), NSLOTS (slot count, power of two, 2..16).
// Configuration macro SWITCH_CAPTURE_DEBOUNCE_EN enables the debounce counter
// inside btn_debounce; without it the press edge comes straight off the
// synchronised button level.
module switch_capture_ctrl
  import switch_capture_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 1_000_000,
  parameter int unsigned TICK_CYCLES = 50_000_000,
  parameter int unsigned NSLOTS      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  switch_capture_ctrl_if.slave  bus
);

  localparam int unsigned IDX_W  = slot_idx_w(NSLOTS);
  localparam int unsigned CNT_W  = IDX_W + 1;
  localparam int unsigned TICK_W = $clog2(TICK_CYCLES);
  localparam int          NS_I   = int'(NSLOTS);

  // Switch synchroniser
  logic [LED_W-1:0] data_s1;
  logic [LED_W-1:0] data_s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_s1 <= '0;
      data_s2 <= '0;
    end else begin
      data_s1 <= bus.data;
      data_s2 <= data_s1;
    end
  end

  // Button press pulses
  logic mode_press;
  logic cap_press;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn_mode (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bus.btn0),
    .press (mode_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn_cap (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bus.btn1),
    .press (cap_press)
  );

  // Controller state and registered outputs
  mode_e             mode_q;
  logic [LED_W-1:0]  slots [NSLOTS];
  logic [IDX_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  slot_cnt;
  logic [IDX_W-1:0]  rd_idx;
  logic [TICK_W-1:0] tick_cnt;
  logic [LED_W-1:0]  led_q;
  logic [LED_W-1:0]  q_q;
  logic              latch_en_q;

  // A capture in the same cycle as a mode press counts toward the bank, so a
  // simultaneous press from an empty bank still enters replay.
  logic bank_nonempty;
  logic last_idx;
  logic tick_done;

  assign bank_nonempty = (slot_cnt != '0) || cap_press;
  assign last_idx      = ({1'b0, rd_idx} == (slot_cnt - CNT_W'(1)));
  assign tick_done     = (tick_cnt == TICK_W'(TICK_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q     <= MODE_LIVE;
      wr_ptr     <= '0;
      slot_cnt   <= '0;
      rd_idx     <= '0;
      tick_cnt   <= '0;
      led_q      <= '0;
      q_q        <= '0;
      latch_en_q <= 1'b0;
      for (int i = 0; i < NS_I; i++) begin
        slots[i] <= '0;
      end
    end else begin
      latch_en_q <= 1'b0;
      case (mode_q)
        MODE_LIVE: begin
          led_q <= data_s2;
          if (cap_press) begin
            slots[wr_ptr] <= data_s2;
            q_q           <= data_s2;
            latch_en_q    <= 1'b1;
            // NSLOTS is a power of two, so the pointer wraps naturally.
            wr_ptr        <= wr_ptr + IDX_W'(1);
            if (slot_cnt != CNT_W'(NSLOTS)) begin
              slot_cnt <= slot_cnt + CNT_W'(1);
            end
          end
          if (mode_press && bank_nonempty) begin
            mode_q   <= MODE_REPLAY;
            rd_idx   <= '0;
            tick_cnt <= '0;
          end
        end
        MODE_REPLAY: begin
          led_q <= slots[rd_idx];
          if (mode_press) begin
            mode_q <= MODE_LIVE;
          end else if (tick_done) begin
            tick_cnt <= '0;
            rd_idx   <= last_idx ? '0 : rd_idx + IDX_W'(1);
          end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
        default: mode_q <= MODE_LIVE;
      endcase
    end
  end

  assign bus.led      = led_q;
  assign bus.q        = q_q;
  assign bus.latch_en = latch_en_q;
  assign bus.mode     = mode_q;
  assign bus.slot_cnt = slot_cnt;
  assign bus.rd_idx   = rd_idx;

endmodule

// File: tb/tb_switch_capture_ctrl.sv
// tb_switch_capture_ctrl: bench for switch_capture_ctrl with DEB_CYCLES=4,
// TICK_CYCLES=8, NSLOTS=4. A behavioural model (slot array + write pointer +
// count) predicts captures and replay contents; expected capture values are
// queued in exp_q and popped whenever latch_en is seen.
module tb_switch_capture_ctrl;
  import switch_capture_pkg::*;

  localparam int unsigned DEB  = 4;
  localparam int unsigned TICK = 8;
  localparam int unsigned NS   = 4;
  localparam int          IW   = 2;
  localparam int          HOLD = int'(DEB) + 6;

  // Clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  switch_capture_ctrl_if #(.NSLOTS(NS)) bus_if ();

  switch_capture_ctrl #(
    .DEB_CYCLES  (DEB),
    .TICK_CYCLES (TICK),
    .NSLOTS      (NS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  // Scoreboard and reference model
  int tests = 0;
  int fails = 0;
  logic [LED_W-1:0] exp_q [$];
  logic [LED_W-1:0] m_slots [NS];
  int               m_wr;
  int               m_cnt;

  function automatic void m_reset();
    for (int i = 0; i < int'(NS); i++) m_slots[i] = '0;
    m_wr  = 0;
    m_cnt = 0;
    exp_q.delete();
  endfunction

  function automatic void m_capture(input logic [LED_W-1:0] v);
    m_slots[m_wr] = v;
    m_wr = (m_wr + 1) % int'(NS);
    if (m_cnt < int'(NS)) m_cnt++;
    exp_q.push_back(v);
  endfunction

  // Driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic watch(input int n, inout int pulses, inout int mode_seen);
    logic prev;
    logic [LED_W-1:0] e;
    prev = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus_if.latch_en === 1'b1) begin
        pulses++;
        tests++;
        if (prev) begin
          fails++;
          $display("FAIL latch_en_single: strobe high two cycles in a row, required one cycle");
        end else if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL latch_en_unexpected: strobe with q=%h, required no strobe", bus_if.q);
        end else begin
          e = exp_q.pop_front();
          if (bus_if.q !== e) begin
            fails++;
            $display("FAIL capture_q: q=%h, required %h", bus_if.q, e);
          end
        end
      end
      if (bus_if.mode === 1'b1) mode_seen = 1;
      prev = bus_if.latch_en;
    end
  endtask

  task automatic press(input int which, inout int pulses, inout int mode_seen);
    if (which == 0) bus_if.btn0 = 1'b1;
    else            bus_if.btn1 = 1'b1;
    watch(HOLD, pulses, mode_seen);
    bus_if.btn0 = 1'b0;
    bus_if.btn1 = 1'b0;
    watch(HOLD, pulses, mode_seen);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus_if.btn0 = 1'b0;
    bus_if.btn1 = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic capture_val(input logic [LED_W-1:0] v);
    int pulses, ms;
    pulses = 0;
    ms = 0;
    bus_if.data = v;
    cyc(3);
    m_capture(v);
    press(1, pulses, ms);
    tests++;
    if (pulses != 1) begin
      fails++;
      $display("FAIL capture_pulses: %0d strobes, required 1", pulses);
    end
    tests++;
    if (bus_if.slot_cnt !== (IW+1)'(m_cnt)) begin
      fails++;
      $display("FAIL slot_cnt: %0d, required %0d", bus_if.slot_cnt, m_cnt);
    end
  endtask

  // Returns at the first negedge where mode reads 1 (entry edge is the
  // posedge just before it).
  task automatic enter_replay();
    int seen;
    seen = 0;
    bus_if.btn0 = 1'b1;
    for (int i = 0; i < 4 * HOLD; i++) begin
      @(negedge clk);
      if (bus_if.mode === 1'b1) begin
        seen = 1;
        break;
      end
    end
    bus_if.btn0 = 1'b0;
    tests++;
    if (seen == 0) begin
      fails++;
      $display("FAIL replay_entry: mode=%b, required 1", bus_if.mode);
    end
    tests++;
    if (bus_if.rd_idx !== IW'(0)) begin
      fails++;
      $display("FAIL replay_entry_idx: rd_idx=%0d, required 0", bus_if.rd_idx);
    end
  endtask

  // Cycle k after entry: led shows slot ((k-1)/TICK mod cnt), rd_idx is
  // (k/TICK mod cnt). Optionally presses btn1, which must be ignored.
  task automatic check_replay(input int n, input int poke);
    int pulses, exp_rd;
    logic [LED_W-1:0] exp_led;
    pulses = 0;
    for (int k = 1; k <= n; k++) begin
      if (poke != 0 && k == 2)        bus_if.btn1 = 1'b1;
      if (poke != 0 && k == 2 + HOLD) bus_if.btn1 = 1'b0;
      @(negedge clk);
      exp_led = m_slots[((k - 1) / int'(TICK)) % m_cnt];
      exp_rd  = (k / int'(TICK)) % m_cnt;
      tests++;
      if (bus_if.led !== exp_led) begin
        fails++;
        $display("FAIL replay_led: cycle %0d led=%h, required %h", k, bus_if.led, exp_led);
      end
      tests++;
      if (bus_if.rd_idx !== IW'(exp_rd) || bus_if.mode !== 1'b1) begin
        fails++;
        $display("FAIL replay_idx: cycle %0d rd_idx=%0d mode=%b, required %0d mode 1",
                 k, bus_if.rd_idx, bus_if.mode, exp_rd);
      end
      if (bus_if.latch_en === 1'b1) pulses++;
    end
    bus_if.btn1 = 1'b0;
    tests++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL replay_no_capture: %0d strobes, required 0", pulses);
    end
  endtask

  task automatic exit_replay();
    int pulses, ms;
    pulses = 0;
    ms = 0;
    press(0, pulses, ms);
    tests++;
    if (bus_if.mode !== 1'b0 || pulses != 0) begin
      fails++;
      $display("FAIL replay_exit: mode=%b strobes=%0d, required mode 0 strobes 0", bus_if.mode, pulses);
    end
    tests++;
    if (bus_if.led !== bus_if.data) begin
      fails++;
      $display("FAIL exit_led_live: led=%h, required %h", bus_if.led, bus_if.data);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_if.data = LED_W'($urandom);
      bus_if.btn0 = 1'($urandom_range(0, 1));
      bus_if.btn1 = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    tests++;
    if (bus_if.led !== 8'h00 || bus_if.q !== 8'h00 || bus_if.latch_en !== 1'b0) begin
      fails++;
      $display("FAIL reset_data: led=%h q=%h latch_en=%b, required 00 00 0",
               bus_if.led, bus_if.q, bus_if.latch_en);
    end
    tests++;
    if (bus_if.mode !== 1'b0 || bus_if.slot_cnt !== 3'd0 || bus_if.rd_idx !== 2'd0) begin
      fails++;
      $display("FAIL reset_ctrl: mode=%b slot_cnt=%0d rd_idx=%0d, required 0 0 0",
               bus_if.mode, bus_if.slot_cnt, bus_if.rd_idx);
    end
    bus_if.data = 8'h00;
    do_reset();
  endtask

  task automatic test_live();
    logic [LED_W-1:0] v;
    cyc(4);
    bus_if.data = 8'hA5;
    cyc(2);
    tests++;
    if (bus_if.led !== 8'h00) begin
      fails++;
      $display("FAIL live_lag: led=%h two cycles after change, required 00", bus_if.led);
    end
    cyc(1);
    tests++;
    if (bus_if.led !== 8'hA5) begin
      fails++;
      $display("FAIL live_a5: led=%h, required a5", bus_if.led);
    end
    bus_if.data = 8'h3C;
    cyc(3);
    tests++;
    if (bus_if.led !== 8'h3C) begin
      fails++;
      $display("FAIL live_3c: led=%h, required 3c", bus_if.led);
    end
    for (int i = 0; i < 4; i++) begin
      v = LED_W'($urandom);
      bus_if.data = v;
      cyc(3);
      tests++;
      if (bus_if.led !== v) begin
        fails++;
        $display("FAIL live_rand: led=%h, required %h", bus_if.led, v);
      end
    end
  endtask

  task automatic test_capture();
    int pulses, ms;
    do_reset();
    capture_val(8'h4D);
    tests++;
    if (bus_if.q !== 8'h4D) begin
      fails++;
      $display("FAIL capture_4d: q=%h, required 4d", bus_if.q);
    end
    pulses = 0;
    ms = 0;
`ifdef SWITCH_CAPTURE_DEBOUNCE_EN
    for (int i = 0; i < 4; i++) begin
      bus_if.btn1 = 1'b1;
      watch(3, pulses, ms);
      bus_if.btn1 = 1'b0;
      watch(3, pulses, ms);
    end
    watch(HOLD, pulses, ms);
    tests++;
    if (pulses != 0 || bus_if.slot_cnt !== 3'd1) begin
      fails++;
      $display("FAIL bounce_filtered: strobes=%0d slot_cnt=%0d, required 0 and 1", pulses, bus_if.slot_cnt);
    end
`else
    m_capture(bus_if.data);
    bus_if.btn1 = 1'b1;
    watch(3, pulses, ms);
    bus_if.btn1 = 1'b0;
    watch(HOLD, pulses, ms);
    tests++;
    if (pulses != 1 || bus_if.slot_cnt !== 3'd2) begin
      fails++;
      $display("FAIL glitch_edge: strobes=%0d slot_cnt=%0d, required 1 and 2", pulses, bus_if.slot_cnt);
    end
`endif
  endtask

  task automatic test_overwrite();
    do_reset();
    for (int i = 1; i <= 5; i++) capture_val(LED_W'(i));
    tests++;
    if (bus_if.slot_cnt !== 3'd4 || m_slots[0] !== 8'h05) begin
      fails++;
      $display("FAIL overwrite_cnt: slot_cnt=%0d, required 4", bus_if.slot_cnt);
    end
    enter_replay();
    check_replay(5 * int'(TICK), 0);
    exit_replay();
  endtask

  task automatic test_replay_timing();
    do_reset();
    capture_val(8'hFF);
    capture_val(8'h00);
    enter_replay();
    check_replay(4 * int'(TICK), 1);
    tests++;
    if (bus_if.slot_cnt !== 3'd2) begin
      fails++;
      $display("FAIL replay_slot_cnt: slot_cnt=%0d, required 2", bus_if.slot_cnt);
    end
    exit_replay();
  endtask

  task automatic test_empty_mode();
    int pulses, ms;
    do_reset();
    pulses = 0;
    ms = 0;
    press(0, pulses, ms);
    tests++;
    if (ms != 0 || bus_if.mode !== 1'b0 || pulses != 0) begin
      fails++;
      $display("FAIL empty_mode: mode_seen=%0d strobes=%0d, required 0 0", ms, pulses);
    end
  endtask

  task automatic test_simultaneous();
    logic [LED_W-1:0] v;
    int seen;
    do_reset();
    v = LED_W'($urandom_range(1, 255));
    bus_if.data = v;
    cyc(3);
    m_capture(v);
    void'(exp_q.pop_front());
    seen = 0;
    bus_if.btn0 = 1'b1;
    bus_if.btn1 = 1'b1;
    for (int i = 0; i < 4 * HOLD; i++) begin
      @(negedge clk);
      if (bus_if.latch_en === 1'b1 || bus_if.mode === 1'b1) begin
        seen = 1;
        break;
      end
    end
    bus_if.btn0 = 1'b0;
    bus_if.btn1 = 1'b0;
    tests++;
    if (seen == 0 || bus_if.latch_en !== 1'b1 || bus_if.mode !== 1'b1) begin
      fails++;
      $display("FAIL simul_press: latch_en=%b mode=%b, required 1 1", bus_if.latch_en, bus_if.mode);
    end
    tests++;
    if (bus_if.q !== v || bus_if.slot_cnt !== 3'd1) begin
      fails++;
      $display("FAIL simul_capture: q=%h slot_cnt=%0d, required %h 1", bus_if.q, bus_if.slot_cnt, v);
    end
    check_replay(3 * int'(TICK), 0);
    exit_replay();
  endtask

  task automatic test_reset_in_replay();
    int pulses, ms;
    do_reset();
    capture_val(LED_W'($urandom_range(1, 255)));
    capture_val(LED_W'($urandom_range(1, 255)));
    enter_replay();
    check_replay(int'(TICK) + 3, 0);
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if (bus_if.mode !== 1'b0 || bus_if.slot_cnt !== 3'd0 || bus_if.rd_idx !== 2'd0 ||
        bus_if.led !== 8'h00 || bus_if.q !== 8'h00) begin
      fails++;
      $display("FAIL reset_replay: mode=%b slot_cnt=%0d rd_idx=%0d led=%h q=%h, required all 0",
               bus_if.mode, bus_if.slot_cnt, bus_if.rd_idx, bus_if.led, bus_if.q);
    end
    rst_n = 1'b1;
    m_reset();
    pulses = 0;
    ms = 0;
    press(0, pulses, ms);
    tests++;
    if (ms != 0) begin
      fails++;
      $display("FAIL reset_bank_empty: mode went to 1, required 0");
    end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 3; it++) begin
      do_reset();
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) capture_val(LED_W'($urandom));
      enter_replay();
      check_replay(2 * m_cnt * int'(TICK), int'($urandom_range(0, 1)));
      exit_replay();
    end
  endtask

  initial begin
    bus_if.data = 8'h00;
    bus_if.btn0 = 1'b0;
    bus_if.btn1 = 1'b0;
    m_reset();
    test_reset();
    test_live();
    test_capture();
    test_overwrite();
    test_replay_timing();
    test_empty_mode();
    test_simultaneous();
    test_reset_in_replay();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
